// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned INSTR_W     = 16;
    localparam int unsigned INSTR_BYTES = 2;

    // F_DISCARD waits out a request made stale by a redirect
    typedef enum logic [1:0] {
        F_IDLE    = 2'd0,
        F_FETCH   = 2'd1,
        F_DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched instructions with their addresses.
// Flush dominates push and pop in the same cycle.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues one request at a time to
// instruction memory and buffers returned instructions for the control unit.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 16,
    parameter int unsigned        DEPTH    = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] Instr,
    output logic [ADDR_W-1:0]  InstrPC,
    output logic               InstrValid,
    input  logic               InstrReady,
    input  logic               PCSrc,
    input  logic [ADDR_W-1:0]  Target
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    fetch_state_t        state;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [ADDR_W-1:0]   req_addr;
    logic [ADDR_W-1:0]   target_pc;
    logic [ADDR_W-1:0]   pc_inc;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_next;
    logic                push;
    logic                pop;
    logic [INSTR_W+ADDR_W-1:0] head;

    assign imem_req   = (state != F_IDLE);
    assign imem_addr  = req_addr;
    assign InstrValid = (count != '0);
    assign target_pc  = {Target[ADDR_W-1:1], 1'b0};
    assign pc_inc     = fetch_pc + ADDR_W'(INSTR_BYTES);

    // Buffer control and post-update occupancy used for request decisions
    always_comb begin
        push       = (state == F_FETCH) && imem_ack && !PCSrc;
        pop        = InstrValid && InstrReady && !PCSrc;
        count_next = PCSrc ? '0 : count + CNT_W'(push) - CNT_W'(pop);
    end

    // Fetch FSM, fetch PC and request address; redirect outranks ack/pop
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= F_IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else if (PCSrc) begin
            fetch_pc <= target_pc;
            case (state)
                F_IDLE: begin
                    state    <= F_FETCH;
                    req_addr <= target_pc;
                end
                F_FETCH: begin
                    if (imem_ack) begin
                        req_addr <= target_pc;
                    end else begin
                        // Request in flight cannot be retracted; drain it first
                        state <= F_DISCARD;
                    end
                end
                F_DISCARD: begin
                    if (imem_ack) begin
                        state    <= F_FETCH;
                        req_addr <= target_pc;
                    end
                end
                default: state <= F_IDLE;
            endcase
        end else begin
            case (state)
                F_IDLE: begin
                    if (count_next < FULL) begin
                        state    <= F_FETCH;
                        req_addr <= fetch_pc;
                    end
                end
                F_FETCH: begin
                    if (imem_ack) begin
                        fetch_pc <= pc_inc;
                        if (count_next < FULL) begin
                            req_addr <= pc_inc;
                        end else begin
                            state <= F_IDLE;
                        end
                    end
                end
                F_DISCARD: begin
                    if (imem_ack) begin
                        state    <= F_FETCH;
                        req_addr <= fetch_pc;
                    end
                end
                default: state <= F_IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH (INSTR_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (PCSrc),
        .wdata ({imem_rdata, req_addr}),
        .rdata (head),
        .count (count)
    );

    assign Instr   = head[INSTR_W+ADDR_W-1:ADDR_W];
    assign InstrPC = head[ADDR_W-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. Memory returns rdata = addr + 0x1000.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] Instr;
    logic [15:0] InstrPC;
    logic        InstrValid;
    logic        InstrReady;
    logic        PCSrc;
    logic [15:0] Target;

    logic        auto_ack;
    logic        man_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_ack   = auto_ack ? imem_req : man_ack;
    assign imem_rdata = imem_addr + 16'h1000;

    instr_fetch #(
        .ADDR_W   (16),
        .DEPTH    (2),
        .RESET_PC (16'h0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .Instr      (Instr),
        .InstrPC    (InstrPC),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .PCSrc      (PCSrc),
        .Target     (Target)
    );

    // Holds reset for two edges, then releases it on a falling edge
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL reset_req got %b want 0", imem_req);
        end
        checks++;
        if (imem_addr !== 16'h0000) begin
            errors++; $display("FAIL reset_addr got %h want 0000", imem_addr);
        end
        checks++;
        if (InstrValid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", InstrValid);
        end
        checks++;
        if (Instr !== 16'h0000 || InstrPC !== 16'h0000) begin
            errors++; $display("FAIL reset_instr got %h/%h want 0000/0000", Instr, InstrPC);
        end
        reset = 1'b0;
    endtask

    // Zero-wait memory, consumer always ready: addr 0,2,4..; Instr one cycle behind
    task automatic test_stream();
        logic [15:0] exp_addr;
        logic [15:0] exp_pc;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            exp_addr = 16'((k - 1) * 2);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
                errors++;
                $display("FAIL stream_req k=%0d got %b/%h want 1/%h", k, imem_req, imem_addr,
                         exp_addr);
            end
            if (k >= 2) begin
                exp_pc = 16'((k - 2) * 2);
                checks++;
                if (InstrValid !== 1'b1 || InstrPC !== exp_pc ||
                    Instr !== exp_pc + 16'h1000) begin
                    errors++;
                    $display("FAIL stream_instr k=%0d got %b/%h/%h want 1/%h/%h", k, InstrValid,
                             InstrPC, Instr, exp_pc, exp_pc + 16'h1000);
                end
            end else begin
                checks++;
                if (InstrValid !== 1'b0) begin
                    errors++; $display("FAIL stream_first_valid got %b want 0", InstrValid);
                end
            end
        end
    endtask

    // Consumer stalled: buffer fills with PC 0,2, request drops, one pop frees one slot
    task automatic test_full();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || InstrValid !== 1'b1 || InstrPC !== 16'h0000) begin
            errors++;
            $display("FAIL full_drop got req=%b v=%b pc=%h want 0/1/0000", imem_req,
                     InstrValid, InstrPC);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL full_hold got req=%b want 0", imem_req);
        end
        InstrReady = 1'b1;
        @(negedge clk);
        InstrReady = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0004 || InstrPC !== 16'h0002 ||
            Instr !== 16'h1002) begin
            errors++;
            $display("FAIL full_refill got req=%b addr=%h pc=%h i=%h want 1/0004/0002/1002",
                     imem_req, imem_addr, InstrPC, Instr);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || InstrPC !== 16'h0002) begin
            errors++;
            $display("FAIL full_refull got req=%b pc=%h want 0/0002", imem_req, InstrPC);
        end
    endtask

    // Memory answers after a 3-cycle wait; address must hold during the wait
    task automatic test_wait();
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 3; w++) begin
                @(negedge clk);
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 16'(i * 2)) begin
                    errors++;
                    $display("FAIL wait_hold i=%0d w=%0d got %b/%h want 1/%h", i, w, imem_req,
                             imem_addr, 16'(i * 2));
                end
            end
            man_ack = 1'b1;
            @(negedge clk);
            man_ack = 1'b0;
            checks++;
            if (InstrValid !== 1'b1 || InstrPC !== 16'(i * 2) || imem_addr !== 16'(i * 2 + 2)) begin
                errors++;
                $display("FAIL wait_deliver i=%0d got v=%b pc=%h addr=%h want 1/%h/%h", i,
                         InstrValid, InstrPC, imem_addr, 16'(i * 2), 16'(i * 2 + 2));
            end
        end
    endtask

    // Redirect with ack, then redirect while waiting: stale reply for 0x0010 dropped
    task automatic test_redirect_discard();
        @(negedge clk);
        man_ack = 1'b1;
        PCSrc   = 1'b1;
        Target  = 16'h0010;
        @(negedge clk);
        man_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0010 || InstrValid !== 1'b0) begin
            errors++;
            $display("FAIL redir_ack got %b/%h v=%b want 1/0010 v=0", imem_req, imem_addr,
                     InstrValid);
        end
        Target = 16'h0041;
        @(negedge clk);
        PCSrc = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0010 || InstrValid !== 1'b0) begin
            errors++;
            $display("FAIL redir_stale got %b/%h v=%b want 1/0010 v=0", imem_req, imem_addr,
                     InstrValid);
        end
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || InstrValid !== 1'b0) begin
            errors++;
            $display("FAIL redir_drop got %b/%h v=%b want 1/0040 v=0", imem_req, imem_addr,
                     InstrValid);
        end
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        checks++;
        if (InstrValid !== 1'b1 || InstrPC !== 16'h0040 || Instr !== 16'h1040) begin
            errors++;
            $display("FAIL redir_first got v=%b pc=%h i=%h want 1/0040/1040", InstrValid,
                     InstrPC, Instr);
        end
    endtask

    // Flush from a full buffer, then flush coinciding with ack and pop, then PC wrap
    task automatic test_flush_wrap();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        InstrReady = 1'b1;
        PCSrc      = 1'b1;
        Target     = 16'h0100;
        @(negedge clk);
        PCSrc = 1'b0;
        checks++;
        if (InstrValid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0100) begin
            errors++;
            $display("FAIL flush_full got v=%b req=%b addr=%h want 0/1/0100", InstrValid,
                     imem_req, imem_addr);
        end
        @(negedge clk);
        checks++;
        if (InstrValid !== 1'b1 || InstrPC !== 16'h0100 || imem_addr !== 16'h0102) begin
            errors++;
            $display("FAIL flush_refetch got v=%b pc=%h addr=%h want 1/0100/0102", InstrValid,
                     InstrPC, imem_addr);
        end
        PCSrc  = 1'b1;
        Target = 16'h0201;
        @(negedge clk);
        PCSrc = 1'b0;
        checks++;
        if (InstrValid !== 1'b0 || imem_addr !== 16'h0200) begin
            errors++;
            $display("FAIL flush_ackpop got v=%b addr=%h want 0/0200", InstrValid, imem_addr);
        end
        @(negedge clk);
        checks++;
        if (InstrValid !== 1'b1 || InstrPC !== 16'h0200 || Instr !== 16'h1200) begin
            errors++;
            $display("FAIL flush_target got v=%b pc=%h i=%h want 1/0200/1200", InstrValid,
                     InstrPC, Instr);
        end
        PCSrc  = 1'b1;
        Target = 16'hFFFE;
        @(negedge clk);
        PCSrc = 1'b0;
        checks++;
        if (imem_addr !== 16'hFFFE) begin
            errors++; $display("FAIL wrap_req got %h want fffe", imem_addr);
        end
        @(negedge clk);
        checks++;
        if (imem_addr !== 16'h0000 || InstrPC !== 16'hFFFE || Instr !== 16'h0FFE) begin
            errors++;
            $display("FAIL wrap_next got addr=%h pc=%h i=%h want 0000/fffe/0ffe", imem_addr,
                     InstrPC, Instr);
        end
    endtask

    // Reset while a request is outstanding
    task automatic test_reset_mid_wait();
        auto_ack = 1'b0;
        man_ack  = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1) begin
            errors++; $display("FAIL midwait_req got %b want 1", imem_req);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || InstrValid !== 1'b0) begin
            errors++;
            $display("FAIL midwait_reset got req=%b addr=%h v=%b want 0/0000/0", imem_req,
                     imem_addr, InstrValid);
        end
    endtask

    initial begin
        reset      = 1'b1;
        auto_ack   = 1'b1;
        man_ack    = 1'b0;
        InstrReady = 1'b1;
        PCSrc      = 1'b0;
        Target     = 16'h0000;

        test_reset();
        test_stream();

        InstrReady = 1'b0;
        apply_reset();
        test_full();

        auto_ack   = 1'b0;
        InstrReady = 1'b1;
        apply_reset();
        test_wait();

        apply_reset();
        test_redirect_discard();

        auto_ack   = 1'b1;
        InstrReady = 1'b0;
        apply_reset();
        test_flush_wrap();
        test_reset_mid_wait();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the 16-bit-instruction single-cycle/multicycle CPU. It is the producer side of the instruction path that the control unit consumes. It owns the fetch PC and issues requests to instruction memory over a req/ack handshake. Returned 16-bit instructions are buffered with their addresses in a small FIFO and presented as Instr/InstrPC with a valid/ready handshake. PCSrc plus a target address flushes the buffer and redirects fetch.

## Interface
Parameters:
- ADDR_W, 16, instruction address width (byte addresses)
- DEPTH, 2, instruction buffer entries; power of two, ≥2
- RESET_PC, 0, fetch address after reset; bit 0 must be 0

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  request to instruction memory
- imem_addr  out  ADDR_W  request address, stable while imem_req=1
- imem_ack  in  1  request completion; only meaningful while imem_req=1
- imem_rdata  in  16  instruction word, valid in the imem_ack cycle
- Instr  out  16  instruction at buffer head
- InstrPC  out  ADDR_W  address of Instr
- InstrValid  out  1  buffer non-empty
- InstrReady  in  1  consumer takes head when InstrValid=1
- PCSrc  in  1  redirect strobe (branch/PC write taken)
- Target  in  ADDR_W  redirect address, sampled when PCSrc=1; bit 0 forced to 0

## Operation
- States: F_IDLE (imem_req=0), F_FETCH (imem_req=1, addr=fetch_pc, data kept), F_DISCARD (imem_req=1, addr=stale request, data dropped).
- imem_req = (state != F_IDLE); imem_addr = req_addr register.
- Priority: reset > PCSrc > ack/pop.
- F_IDLE: if count < DEPTH → F_FETCH, req_addr ← fetch_pc.
- F_FETCH, ack, no PCSrc: push {imem_rdata, req_addr}; fetch_pc ← fetch_pc+2 (mod 2^ADDR_W). Stay F_FETCH with req_addr ← new fetch_pc if post-update count < DEPTH, else → F_IDLE.
- PCSrc=1 in any state: buffer flushed (count←0, pop and push ignored this cycle); fetch_pc ← {Target[ADDR_W-1:1],0}.
  - F_IDLE → F_FETCH, or F_FETCH with ack → F_FETCH; req_addr ← new fetch_pc.
  - F_FETCH without ack → F_DISCARD, req_addr unchanged.
  - F_DISCARD: fetch_pc updated; if ack → F_FETCH.
- F_DISCARD, ack → F_FETCH, req_addr ← fetch_pc; returned data never pushed.
- Pop when InstrValid & InstrReady & !PCSrc. Push and pop in the same cycle: count unchanged, legal at count=DEPTH-1 or any non-empty level.
- At most one memory request outstanding; address never changes while imem_req=1 and no ack.

## Timing
- Reset values: state F_IDLE, imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, count=0, InstrValid=0, Instr=0, InstrPC=0.
- First request: imem_req=1 in cycle 1 after reset deassertion.
- Zero-wait memory (ack same cycle as req): Instr valid 1 cycle after ack; sustained 1 instr/cycle when the consumer is always ready.
- Redirect: InstrValid=0 in the cycle after PCSrc. Request to Target goes out that cycle unless a stale request is still draining (F_DISCARD).
- Buffer full: imem_req drops the cycle after the filling ack. It reasserts the cycle after a pop frees space.
- Instr/InstrPC registered from FIFO storage; hold stable while InstrValid=1 and not popped.

## Structure
- Package fetch_pkg: typedef enum fetch_state_t {F_IDLE, F_FETCH, F_DISCARD}; INSTR_W=16; INSTR_BYTES=2.
- Sub-module fetch_fifo: synchronous FIFO, width INSTR_W+ADDR_W, depth DEPTH, ports push/pop/flush/count, with flush dominant.
- instr_fetch holds the FSM, fetch_pc, req_addr.

## Test plan
- Reset, zero-wait ack, InstrReady=1 → imem_addr 0,2,4,6…; Instr/InstrPC follow one cycle later; InstrValid continuous from cycle 2.
- InstrReady=0, DEPTH=2 → exactly two acks accepted (PC 0,2), imem_req low. Raise InstrReady for one cycle → one new request at addr 4.
- Memory ack delayed 3 cycles → imem_addr held stable across the wait, one instruction per 4 cycles.
- PCSrc=1, Target=0x0041 while F_FETCH waiting on addr 0x0010 → F_DISCARD. Ack for 0x0010 is dropped; next request addr 0x0040; first Instr shows InstrPC=0x0040.
- PCSrc coinciding with ack, pop, and a full buffer → buffer empty next cycle, nothing pushed, next request at Target.
- fetch_pc at 0xFFFE with ADDR_W=16 → next request addr 0x0000. Reset mid-wait → imem_req=0 next cycle, addr=RESET_PC.
